// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared widths, reset vector, bubble encoding and state types
package instruction_fetch_unit_pkg;

    localparam int          IFU_WORD_WIDTH   = 32;
    localparam logic [31:0] IFU_RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] IFU_BUBBLE_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        DRAIN = 2'd2
    } ifu_state_e;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_op_e;

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// if_id_register: IF/ID pipeline register with load, hold and bubble-flush operations
module if_id_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter int W = IFU_WORD_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  ifid_op_e     op_i,
    input  logic [W-1:0] pc_i,
    input  logic [W-1:0] instr_i,
    output logic [W-1:0] pc_o,
    output logic [W-1:0] instr_o,
    output logic         valid_o
);

    logic [W-1:0] pc_q, instr_q;
    logic         valid_q;

    // A bubble keeps the last PC so downstream sees a stable address while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (op_i == IFID_LOAD) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end else if (op_i == IFID_BUBBLE) begin
            instr_q <= W'(IFU_BUBBLE_INSTR);
            valid_q <= 1'b0;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: request/ready fetch FSM with one-entry stall buffer and branch drain
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                    WORD_WIDTH = IFU_WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = WORD_WIDTH'(IFU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Freeze,
    input  logic                  Branch_taken,
    input  logic [WORD_WIDTH-1:0] Branch_address,
    output logic                  imem_req,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    output logic [WORD_WIDTH-1:0] PC_out,
    output logic [WORD_WIDTH-1:0] instruction_out,
    output logic                  valid_out
);

    ifu_state_e            state_q, state_d;
    logic [WORD_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [WORD_WIDTH-1:0] buf_q, buf_d;
    logic [WORD_WIDTH-1:0] pend_q, pend_d;
    logic [WORD_WIDTH-1:0] next_addr;
    ifid_op_e              ifid_op;
    logic [WORD_WIDTH-1:0] ifid_instr;

    assign next_addr = req_addr_q + WORD_WIDTH'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            req_addr_q <= RESET_PC;
            buf_q      <= '0;
            pend_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            buf_q      <= buf_d;
            pend_q     <= pend_d;
        end
    end

    // req_addr only moves on a completion or when leaving STALL, so the request stays stable
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        buf_d      = buf_q;
        pend_d     = pend_q;
        case (state_q)
            FETCH: begin
                if (Branch_taken) begin
                    if (imem_ready) begin
                        req_addr_d = Branch_address;
                    end else begin
                        pend_d  = Branch_address;
                        state_d = DRAIN;
                    end
                end else if (imem_ready) begin
                    if (Freeze) begin
                        buf_d   = imem_rdata;
                        state_d = STALL;
                    end else begin
                        req_addr_d = next_addr;
                    end
                end
            end
            STALL: begin
                if (Branch_taken) begin
                    req_addr_d = Branch_address;
                    buf_d      = '0;
                    state_d    = FETCH;
                end else if (!Freeze) begin
                    req_addr_d = next_addr;
                    buf_d      = '0;
                    state_d    = FETCH;
                end
            end
            DRAIN: begin
                if (Branch_taken) pend_d = Branch_address;
                if (imem_ready) begin
                    req_addr_d = Branch_taken ? Branch_address : pend_q;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        imem_req   = state_q != STALL;
        imem_addr  = req_addr_q;
        ifid_instr = state_q == STALL ? buf_q : imem_rdata;
        ifid_op    = IFID_HOLD;
        if (Branch_taken || state_q == DRAIN)
            ifid_op = IFID_BUBBLE;
        else if (state_q == FETCH)
            ifid_op = Freeze ? IFID_HOLD : (imem_ready ? IFID_LOAD : IFID_BUBBLE);
        else if (state_q == STALL)
            ifid_op = Freeze ? IFID_HOLD : IFID_LOAD;
    end

    if_id_register #(.W(WORD_WIDTH)) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .op_i    (ifid_op),
        .pc_i    (next_addr),
        .instr_i (ifid_instr),
        .pc_o    (PC_out),
        .instr_o (instruction_out),
        .valid_o (valid_out)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed vectors with hand-computed expectations for the fetch unit
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, Freeze, Branch_taken, imem_ready;
    logic [31:0] Branch_address, imem_rdata;
    logic        imem_req, valid_out;
    logic [31:0] imem_addr, PC_out, instruction_out;
    int          n_vec = 0;
    int          n_bad = 0;

    instruction_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .Freeze          (Freeze),
        .Branch_taken    (Branch_taken),
        .Branch_address  (Branch_address),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .PC_out          (PC_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic fz, input logic br, input logic [31:0] ba,
                         input logic rdy, input logic [31:0] rd);
        rst = r; Freeze = fz; Branch_taken = br; Branch_address = ba; imem_ready = rdy; imem_rdata = rd;
    endtask

    task automatic expect_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                               input logic v, input logic req, input logic [31:0] addr);
        check({tag, ".pc"}, PC_out, pc);
        check({tag, ".ins"}, instruction_out, ins);
        check({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
        check({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
        check({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);
        step(); step();
        drive(0, 0, 0, 0, 0, 0);
        expect_ifid("reset", 0, 0, 0, 1, 0);
        // zero-wait stream
        drive(0, 0, 0, 0, 1, 32'hA0); step(); expect_ifid("zw0", 32'h4, 32'hA0, 1, 1, 32'h4);
        drive(0, 0, 0, 0, 1, 32'hA1); step(); expect_ifid("zw1", 32'h8, 32'hA1, 1, 1, 32'h8);
        drive(0, 0, 0, 0, 1, 32'hA2); step(); expect_ifid("zw2", 32'hC, 32'hA2, 1, 1, 32'hC);
        // wait states at 0x10
        drive(0, 0, 0, 0, 1, 32'hB0); step(); expect_ifid("to10", 32'h10, 32'hB0, 1, 1, 32'h10);
        drive(0, 0, 0, 0, 0, 0);      step(); expect_ifid("ws1", 32'h10, 0, 0, 1, 32'h10);
        step();                               expect_ifid("ws2", 32'h10, 0, 0, 1, 32'h10);
        drive(0, 0, 0, 0, 1, 32'hC0); step(); expect_ifid("ws3", 32'h14, 32'hC0, 1, 1, 32'h14);
        // freeze on completion
        drive(0, 1, 0, 0, 1, 32'hE3A01005); step(); expect_ifid("fz1", 32'h14, 32'hC0, 1, 0, 32'h14);
        drive(0, 1, 0, 0, 0, 0); step();            expect_ifid("fz2", 32'h14, 32'hC0, 1, 0, 32'h14);
        step();                                      expect_ifid("fz3", 32'h14, 32'hC0, 1, 0, 32'h14);
        drive(0, 0, 0, 0, 0, 0); step();            expect_ifid("fz4", 32'h18, 32'hE3A01005, 1, 1, 32'h18);
        // branch while request at 0x20 waits
        drive(0, 0, 0, 0, 1, 32'hD0); step(); expect_ifid("to1c", 32'h1C, 32'hD0, 1, 1, 32'h1C);
        drive(0, 0, 0, 0, 1, 32'hD1); step(); expect_ifid("to20", 32'h20, 32'hD1, 1, 1, 32'h20);
        drive(0, 0, 1, 32'h100, 0, 0); step(); expect_ifid("dr1", 32'h20, 0, 0, 1, 32'h20);
        drive(0, 0, 0, 0, 0, 0); step();       expect_ifid("dr2", 32'h20, 0, 0, 1, 32'h20);
        drive(0, 0, 0, 0, 1, 32'hBAD); step(); expect_ifid("dr3", 32'h20, 0, 0, 1, 32'h100);
        // branch plus freeze while stalled
        drive(0, 1, 0, 0, 1, 32'hF0); step(); expect_ifid("bs1", 32'h20, 0, 0, 0, 32'h100);
        drive(0, 1, 1, 32'h200, 0, 0); step(); expect_ifid("bs2", 32'h20, 0, 0, 1, 32'h200);
        drive(0, 0, 0, 0, 1, 32'h11); step();  expect_ifid("bs3", 32'h204, 32'h11, 1, 1, 32'h204);
        // wraparound
        drive(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h99); step(); expect_ifid("wr1", 32'h204, 0, 0, 1, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 1, 32'h22); step();             expect_ifid("wr2", 32'h0, 32'h22, 1, 1, 32'h0);
        drive(0, 0, 0, 0, 1, 32'h44); step();             expect_ifid("wr3", 32'h4, 32'h44, 1, 1, 32'h4);
        // reset with a request outstanding and ready, branch and freeze
        drive(0, 0, 0, 0, 0, 0); step();                   expect_ifid("rs0", 32'h4, 0, 0, 1, 32'h4);
        drive(1, 1, 1, 32'h300, 1, 32'h55); step();        expect_ifid("rs1", 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 32'h66); step();              expect_ifid("rs2", 32'h4, 32'h66, 1, 1, 32'h4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
